// File: rtl/hazard_pkg.sv
// Shared types, defaults and helpers for the ID-stage branch hazard controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int REG_ADDR_W_DEF = 4;
    localparam int LOAD_STALL_DEF = 2;
    localparam int ALU_STALL_DEF  = 1;

    // Register addresses are widened to this size before matching, so one
    // function serves any REG_ADDR_W up to this width.
    localparam int MATCH_W = 8;

    // True when rd is a real (non-zero) register that feeds rs1 or rs2.
    function automatic logic reg_match(input logic [MATCH_W-1:0] rd,
                                       input logic [MATCH_W-1:0] rs1,
                                       input logic [MATCH_W-1:0] rs2);
        return (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that saturates at 16'hFFFF; sync clear, async reset.
// Latency: count updates at the clock edge after en is seen.
// Backpressure: none; en is sampled every cycle.
// Ports: clk, rst (async active-high), en (count), clr (sync clear), cnt.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencer: stalls PC/IF-ID while branch operands are in
// flight in EX/MEM, then redirects the PC and flushes IF/ID on taken/jump.
// Latency: control outputs are combinational from state and ID/EX/MEM inputs.
// Backpressure: produces stalls only; nothing it consumes can be held off.
// Ports: id_* describe the ID instruction, ex_*/mem_* the in-flight producers,
// branch_taken is the raw comparator result; pc_stall/ifid_stall/idex_bubble,
// ifid_flush/pc_redirect steer the front end; busy flags a non-IDLE FSM.
// Optional: define BRANCH_PERF_CNT_EN to add perf_taken/perf_stall counters.
module branch_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int LOAD_STALL = LOAD_STALL_DEF,
    parameter int ALU_STALL  = ALU_STALL_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_memread,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  branch_taken,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_bubble,
    output logic                  ifid_flush,
    output logic                  pc_redirect,
    output logic                  busy
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [15:0]           perf_taken,
    output logic [15:0]           perf_stall
`endif
);

    state_t     state_q, state_d;
    logic [1:0] stall_cnt_q, stall_cnt_d;

    logic [MATCH_W-1:0] rs1_x, rs2_x, ex_rd_x, mem_rd_x;
    logic               is_branch;
    logic               hz_load;
    logic               hz_alu;
    logic [1:0]         stall_len;

    assign rs1_x    = MATCH_W'(id_rs1);
    assign rs2_x    = MATCH_W'(id_rs2);
    assign ex_rd_x  = MATCH_W'(ex_rd);
    assign mem_rd_x = MATCH_W'(mem_rd);

    assign is_branch = id_valid && id_branch;

    assign hz_load = is_branch && ex_memread && reg_match(ex_rd_x, rs1_x, rs2_x);
    // A load in MEM costs the same as an ALU result in EX: one more cycle
    // until it reaches a point the ID comparator can forward from.
    assign hz_alu  = is_branch &&
                     ((ex_regwrite && !ex_memread && reg_match(ex_rd_x, rs1_x, rs2_x)) ||
                      (mem_memread && reg_match(mem_rd_x, rs1_x, rs2_x)));

    assign stall_len = hz_load ? 2'(LOAD_STALL) : 2'(ALU_STALL);

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        pc_redirect = 1'b0;

        case (state_q)
            IDLE: begin
                // Jumps take precedence and never wait on operands.
                if (id_valid && id_jump) begin
                    pc_redirect = 1'b1;
                    ifid_flush  = 1'b1;
                    state_d     = FLUSH;
                end else if (is_branch) begin
                    if (hz_load || hz_alu) begin
                        // This detect cycle is the first stall cycle.
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                        if (stall_len > 2'd1) begin
                            stall_cnt_d = stall_len - 2'd1;
                            state_d     = STALL;
                        end
                    end else if (branch_taken) begin
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        state_d     = FLUSH;
                    end
                end
            end

            STALL: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
                stall_cnt_d = stall_cnt_q - 2'd1;
                // <= 1 also recovers from a zero count rather than wrapping.
                if (stall_cnt_q <= 2'd1) begin
                    stall_cnt_d = 2'd0;
                    state_d     = IDLE;
                end
            end

            FLUSH: begin
                // The ID slot holds the squashed instruction; ignore it.
                state_d = IDLE;
            end

            default: begin
                state_d     = IDLE;
                stall_cnt_d = 2'd0;
            end
        endcase

        // Keep the front end quiet for the whole reset pulse.
        if (rst) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            idex_bubble = 1'b0;
            ifid_flush  = 1'b0;
            pc_redirect = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stall_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy = (state_q != IDLE) && !rst;

`ifdef BRANCH_PERF_CNT_EN
    sat_counter16 u_perf_taken (
        .clk (clk),
        .rst (rst),
        .en  (pc_redirect),
        .clr (1'b0),
        .cnt (perf_taken)
    );

    sat_counter16 u_perf_stall (
        .clk (clk),
        .rst (rst),
        .en  (pc_stall),
        .clr (1'b0),
        .cnt (perf_stall)
    );
`endif

endmodule
